// File: rtl/mod_exp_pkg.sv
// Shared types and constants for the square-and-multiply exponentiation controller.
package mod_exp_pkg;

  localparam int WIDTH     = 256;
  localparam int EXP_WIDTH = 256;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SCAN    = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    RECOVER = 3'd4,
    FIN     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SQR  = 2'd1,
    MUL  = 2'd2
  } op_e;

endpackage

// File: rtl/exp_bit_scanner.sv
// Holds the captured exponent and walks a bit index from the MSB down to bit 0.
module exp_bit_scanner #(
  parameter int EXP_WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 dec,
  input  logic [EXP_WIDTH-1:0] exp_in,
  output logic                 cur_bit,
  output logic                 is_last
);

  localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  logic [EXP_WIDTH-1:0] e_q, e_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  // Next exponent copy and index: load wins over decrement.
  always_comb begin
    e_d   = e_q;
    idx_d = idx_q;
    if (load) begin
      e_d   = exp_in;
      idx_d = IDX_W'(EXP_WIDTH - 1);
    end else if (dec) begin
      idx_d = idx_q - IDX_W'(1);
    end else begin
      idx_d = idx_q;
    end
  end

  // Scanner registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q   <= '0;
      idx_q <= '0;
    end else begin
      e_q   <= e_d;
      idx_q <= idx_d;
    end
  end

  assign cur_bit = e_q[idx_q];
  assign is_last = (idx_q == '0);

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply controller sequencing an external modular
// multiplier through its start/done/reset handshake.
module mod_exp_ctrl #(
  parameter int WIDTH     = mod_exp_pkg::WIDTH,
  parameter int EXP_WIDTH = mod_exp_pkg::EXP_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exp,
  output logic                 busy,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic [WIDTH-1:0]     mm_x,
  output logic [WIDTH-1:0]     mm_y,
  output logic                 mm_start,
  output logic                 mm_rst,
  input  logic [WIDTH-1:0]     mm_q,
  input  logic                 mm_done
);

  import mod_exp_pkg::*;

  localparam logic [WIDTH-1:0] ACC_ONE = WIDTH'(ONE);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] mm_x_q, mm_x_d;
  logic [WIDTH-1:0] mm_y_q, mm_y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mm_start_q, mm_start_d;
  logic             started_q, started_d;
  logic             scan_load, scan_dec;
  logic             cur_bit, is_last;

  exp_bit_scanner #(.EXP_WIDTH(EXP_WIDTH)) u_scanner (
    .clk     (clk),
    .rst     (rst),
    .load    (scan_load),
    .dec     (scan_dec),
    .exp_in  (exp),
    .cur_bit (cur_bit),
    .is_last (is_last)
  );

  // Next-state and registered-output logic for the sequencing FSM.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    acc_d      = acc_q;
    base_d     = base_q;
    result_d   = result_q;
    mm_x_d     = mm_x_q;
    mm_y_d     = mm_y_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mm_start_d = mm_start_q;
    started_d  = started_q;
    scan_load  = 1'b0;
    scan_dec   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d    = base;
          acc_d     = ACC_ONE;
          started_d = 1'b0;
          scan_load = 1'b1;
          busy_d    = 1'b1;
          state_d   = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (cur_bit) begin
          // First set bit: reduce the base into the accumulator via base*1.
          op_d       = LOAD;
          started_d  = 1'b1;
          mm_x_d     = base_q;
          mm_y_d     = ACC_ONE;
          mm_start_d = 1'b1;
          state_d    = ISSUE;
        end else if (is_last) begin
          result_d = acc_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = FIN;
        end else begin
          scan_dec = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (mm_done) begin
          acc_d      = mm_q;
          mm_start_d = 1'b0;
          state_d    = RECOVER;
        end else begin
          state_d = WAIT;
        end
      end
      RECOVER: begin
        // LOAD and MUL both finish the current bit, so only SQR can chain to MUL.
        if ((op_q == SQR) && cur_bit) begin
          op_d       = MUL;
          mm_x_d     = acc_q;
          mm_y_d     = base_q;
          mm_start_d = 1'b1;
          state_d    = ISSUE;
        end else if (is_last) begin
          result_d = acc_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = FIN;
        end else begin
          scan_dec   = 1'b1;
          op_d       = SQR;
          mm_x_d     = acc_q;
          mm_y_d     = acc_q;
          mm_start_d = 1'b1;
          state_d    = ISSUE;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= LOAD;
      acc_q      <= '0;
      base_q     <= '0;
      result_q   <= '0;
      mm_x_q     <= '0;
      mm_y_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mm_start_q <= 1'b0;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      base_q     <= base_d;
      result_q   <= result_d;
      mm_x_q     <= mm_x_d;
      mm_y_q     <= mm_y_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mm_start_q <= mm_start_d;
      started_q  <= started_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign mm_x     = mm_x_q;
  assign mm_y     = mm_y_q;
  assign mm_start = mm_start_q;
  assign mm_rst   = rst | (state_q == RECOVER);

endmodule
